// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and
// the helper that sizes the bit-slice counter.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Counter holds 0..WIDTH so the final increment never wraps.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single-bit full-adder cell, time-shared across all bit slices.
module fa_bit (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell iterated LSB first over WIDTH cycles.
// Optional SERIAL_ADD_SUB_EN adds a subtract request (sub) and signed overflow (ovf).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADD_SUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CW-1:0]    count_q, count_d;
  logic             s_bit, c_bit;
`ifdef SERIAL_ADD_SUB_EN
  logic             ovf_q, ovf_d;
`endif

  fa_bit u_fa (
    .s  (s_bit),
    .co (c_bit),
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    co_d     = co_q;
    count_d  = count_q;
`ifdef SERIAL_ADD_SUB_EN
    ovf_d    = ovf_q;
`endif
    busy     = (state_q == RUN);
    done     = (state_q == FIN);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = ci;
`ifdef SERIAL_ADD_SUB_EN
          if (sub) begin
            b_sh_d  = ~b;
            carry_d = 1'b1;
          end
`endif
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1] = s_bit;
        carry_d  = c_bit;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          // Result registers load on the edge into FIN so sum/co are
          // already valid in the cycle done is asserted.
          sum_d   = sum_sh_d;
          co_d    = c_bit;
`ifdef SERIAL_ADD_SUB_EN
          ovf_d   = carry_q ^ c_bit;
`endif
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      co_q     <= 1'b0;
      count_q  <= '0;
`ifdef SERIAL_ADD_SUB_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      co_q     <= co_d;
      count_q  <= count_d;
`ifdef SERIAL_ADD_SUB_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign sum = sum_q;
  assign co  = co_q;
`ifdef SERIAL_ADD_SUB_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, ci = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, co;
  logic [W-1:0] sum;
  logic         start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
  logic         busy1, done1, co1, sum1;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0, sub1 = 1'b0;
  logic         ovf, ovf1;
`endif

  int total = 0;
  int bad   = 0;

  logic [W:0]   exp_q[$];
  logic [1:0]   exp1_q[$];
  logic [W-1:0] last_sum = '0;
  logic         last_co  = 1'b0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co)
`ifdef SERIAL_ADD_SUB_EN
    , .sub(sub), .ovf(ovf)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1)
`ifdef SERIAL_ADD_SUB_EN
    , .sub(sub1), .ovf(ovf1)
`endif
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, co, sum} !== '0) begin
      bad++;
      $display("FAIL reset_w8: busy=%b done=%b co=%b sum=%h want all 0", busy, done, co, sum);
    end
    total++;
    if ({busy1, done1, co1, sum1} !== 4'b0) begin
      bad++;
      $display("FAIL reset_w1: busy=%b done=%b co=%b sum=%b want all 0", busy1, done1, co1, sum1);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, co, sum} !== '0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%b done=%b co=%b sum=%h want all 0", busy, done, co, sum);
    end
    last_sum = '0;
    last_co  = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [0:2] = '{8'h5A, 8'hFF, 8'hFF};
    logic [W-1:0] tb_ [0:2] = '{8'h3C, 8'h01, 8'hFF};
    logic         tc [0:2] = '{1'b0, 1'b0, 1'b1};
    logic [W:0]   want;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) begin
        a = ta[i]; b = tb_[i]; ci = tc[i];
      end else begin
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom_range(0, 1));
      end
      start = 1'b1;
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci});
      for (int k = 1; k <= int'(W) + 1; k++) begin
        @(negedge clk);
        start = 1'b0;
        total++;
        if (k <= int'(W)) begin
          if ({busy, done, co, sum} !== {2'b10, last_co, last_sum}) begin
            bad++;
            $display("FAIL basic_run op%0d cyc%0d: busy=%b done=%b co=%b sum=%h want busy=1 done=0 co=%b sum=%h",
                     i, k, busy, done, co, sum, last_co, last_sum);
          end
        end else if (done === 1'b1 && exp_q.size() > 0) begin
          want = exp_q.pop_front();
          if ({busy, co, sum} !== {1'b0, want}) begin
            bad++;
            $display("FAIL basic_result op%0d: busy=%b co=%b sum=%h want busy=0 co=%b sum=%h",
                     i, busy, co, sum, want[W], want[W-1:0]);
          end
          last_co = want[W]; last_sum = want[W-1:0];
        end else begin
          bad++;
          $display("FAIL basic_done_latency op%0d: done=%b at cycle %0d want 1", i, done, k);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      @(negedge clk);
      total++;
      if ({busy, done, co, sum} !== {2'b00, last_co, last_sum}) begin
        bad++;
        $display("FAIL basic_hold op%0d: busy=%b done=%b co=%b sum=%h want busy=0 done=0 co=%b sum=%h",
                 i, busy, done, co, sum, last_co, last_sum);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         phase = 0;
    int         n_done = 0;
    logic [1:0] exp_bd;
    logic [W:0] want;
    for (int cyc = 0; cyc < 60 + int'(W) + 3; cyc++) begin
      @(negedge clk);
      exp_bd = (phase == 0) ? 2'b00 : ((phase <= int'(W)) ? 2'b10 : 2'b01);
      total++;
      if ({busy, done} !== exp_bd) begin
        bad++;
        $display("FAIL b2b_handshake cyc%0d: busy=%b done=%b want %b", cyc, busy, done, exp_bd);
      end
      if (done === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_unexpected_done cyc%0d: co=%b sum=%h want no result", cyc, co, sum);
        end else begin
          want = exp_q.pop_front();
          n_done++;
          if ({co, sum} !== want) begin
            bad++;
            $display("FAIL b2b_result cyc%0d: co=%b sum=%h want co=%b sum=%h", cyc, co, sum, want[W], want[W-1:0]);
          end
          last_co = want[W]; last_sum = want[W-1:0];
        end
      end else begin
        total++;
        if ({co, sum} !== {last_co, last_sum}) begin
          bad++;
          $display("FAIL b2b_hold cyc%0d: co=%b sum=%h want co=%b sum=%h", cyc, co, sum, last_co, last_sum);
        end
      end
      start = (cyc < 60);
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom_range(0, 1));
      if (phase == 0) begin
        if (start) begin
          exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci});
          phase = 1;
        end
      end else if (phase == int'(W) + 1) begin
        phase = 0;
      end else begin
        phase++;
      end
    end
    start = 1'b0;
    total++;
    if (n_done != 6 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_op_count: done pulses=%0d pending=%0d want 6 and 0", n_done, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W:0] want;
    bit         seen_done = 1'b0;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; ci = 1'b1; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy_before: busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, co, sum} !== '0) begin
      bad++;
      $display("FAIL midrst_abort: busy=%b done=%b co=%b sum=%h want all 0", busy, done, co, sum);
    end
    for (int k = 0; k < int'(W) + 2; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done) begin
      bad++;
      $display("FAIL midrst_no_done: activity after abort=1 want 0");
    end
    last_co = 1'b0; last_sum = '0;
    a = 8'h01; b = 8'h01; ci = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci});
    for (int k = 1; k <= int'(W) + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (done === 1'b1 && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      if ({co, sum} !== want) begin
        bad++;
        $display("FAIL midrst_next_op: co=%b sum=%h want co=%b sum=%h", co, sum, want[W], want[W-1:0]);
      end
      last_co = want[W]; last_sum = want[W-1:0];
    end else begin
      bad++;
      $display("FAIL midrst_next_done: done=%b want 1", done);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_width1();
    logic [1:0] want;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      {a1, b1, ci1} = v;
      start1 = 1'b1;
      exp1_q.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, ci1});
      @(negedge clk);
      start1 = 1'b0;
      total++;
      if ({busy1, done1} !== 2'b10) begin
        bad++;
        $display("FAIL w1_run combo%0d: busy=%b done=%b want busy=1 done=0", i, busy1, done1);
      end
      @(negedge clk);
      total++;
      if (done1 === 1'b1 && exp1_q.size() > 0) begin
        want = exp1_q.pop_front();
        if ({busy1, co1, sum1} !== {1'b0, want}) begin
          bad++;
          $display("FAIL w1_result combo%0d: busy=%b co=%b sum=%b want busy=0 co=%b sum=%b",
                   i, busy1, co1, sum1, want[1], want[0]);
        end
      end else begin
        bad++;
        $display("FAIL w1_done combo%0d: done=%b want 1", i, done1);
        if (exp1_q.size() > 0) void'(exp1_q.pop_front());
      end
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    logic [W-1:0] ta [0:2] = '{8'h10, 8'h80, 8'h05};
    logic [W-1:0] tb_ [0:2] = '{8'h03, 8'h01, 8'h09};
    logic [W:0]   want;
    logic         want_ovf;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb_[i]; ci = 1'b0; sub = 1'b1; start = 1'b1;
      want = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
      want_ovf = (a[W-1] != b[W-1]) && (want[W-1] != a[W-1]);
      exp_q.push_back(want);
      for (int k = 1; k <= int'(W) + 1; k++) begin
        @(negedge clk);
        start = 1'b0; sub = 1'b0;
      end
      total++;
      if (done === 1'b1 && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        if ({co, sum, ovf} !== {want, want_ovf}) begin
          bad++;
          $display("FAIL sub_result op%0d: co=%b sum=%h ovf=%b want co=%b sum=%h ovf=%b",
                   i, co, sum, ovf, want[W], want[W-1:0], want_ovf);
        end
        last_co = want[W]; last_sum = want[W-1:0];
      end else begin
        bad++;
        $display("FAIL sub_done op%0d: done=%b want 1", i, done);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
